// File: rtl/quarter_sine_nco.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : quarter_sine_nco
// Description : Phase-accumulator NCO producing an 11-bit unsigned full-wave
//               sine sample stream from a 256-entry quarter-sine BRAM. Each
//               sample tick captures the phase, mirrors the table address,
//               and folds the sign using the quadrant carried in a pipeline
//               that runs alongside the 1-cycle BRAM read.
// Revision    : 1.0 - initial release
// ============================================================================
module quarter_sine_nco #(
    parameter int SAMPLE_DIV = 1494,
    parameter int PHASE_W    = 24,
    parameter int TUNE_W     = 16
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [TUNE_W-1:0] tune,
    input  logic              enable,
    output logic [7:0]        addra,
    input  logic [10:0]       douta,
    output logic [10:0]       sample,
    output logic              sample_valid
);

    localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [10:0]      MIDSCALE = 11'd1024;

    // Sample-rate divider
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick;

    // Phase accumulator
    logic [PHASE_W-1:0] phase_q, phase_d;

    // Stage 1: address issued to BRAM, quadrant/mute travel with it
    logic [7:0]         addra_q, addra_d;
    logic [1:0]         quad1_q, quad1_d;
    logic               mute1_q, mute1_d;
    logic               vld1_q, vld1_d;

    // Stage 2: BRAM data arriving, quadrant/mute aligned with it
    logic [1:0]         quad2_q, quad2_d;
    logic               mute2_q, mute2_d;
    logic               vld2_q, vld2_d;

    // Output stage
    logic [10:0]        sample_q, sample_d;
    logic               sample_valid_q, sample_valid_d;

    // Decode of the live phase, used only at tick
    logic [1:0]         cur_quad;
    logic [7:0]         cur_idx;

    // Table entries never set bit 10; it is intentionally ignored
    logic               douta_msb_unused;

    assign tick             = (div_q == DIV_LAST);
    assign cur_quad         = phase_q[PHASE_W-1 -: 2];
    assign cur_idx          = phase_q[PHASE_W-3 -: 8];
    assign douta_msb_unused = douta[10];

    // State registers; asynchronous reset discards any in-flight sample
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_q          <= '0;
            phase_q        <= '0;
            addra_q        <= '0;
            quad1_q        <= '0;
            mute1_q        <= 1'b0;
            vld1_q         <= 1'b0;
            quad2_q        <= '0;
            mute2_q        <= 1'b0;
            vld2_q         <= 1'b0;
            sample_q       <= MIDSCALE;
            sample_valid_q <= 1'b0;
        end else begin
            div_q          <= div_d;
            phase_q        <= phase_d;
            addra_q        <= addra_d;
            quad1_q        <= quad1_d;
            mute1_q        <= mute1_d;
            vld1_q         <= vld1_d;
            quad2_q        <= quad2_d;
            mute2_q        <= mute2_d;
            vld2_q         <= vld2_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    // Next-state: divider, accumulator, address mirror and sign fold
    always_comb begin
        div_d          = tick ? '0 : div_q + DIV_W'(1);
        phase_d        = phase_q;
        addra_d        = addra_q;
        quad1_d        = quad1_q;
        mute1_d        = mute1_q;
        vld1_d         = tick;
        quad2_d        = quad1_q;
        mute2_d        = mute1_q;
        vld2_d         = vld1_q;
        sample_d       = sample_q;
        sample_valid_d = vld2_q;

        if (tick) begin
            mute1_d = ~enable;
            quad1_d = cur_quad;
            if (enable) begin
                // Odd quadrants read the table backwards: 255 - idx == ~idx
                addra_d = cur_quad[0] ? ~cur_idx : cur_idx;
                phase_d = phase_q + PHASE_W'(tune);
            end else begin
                phase_d = '0;
            end
        end

        if (vld2_q) begin
            if (mute2_q) begin
                sample_d = MIDSCALE;
            end else if (quad2_q[1]) begin
                // Negative half: 1023 - m is the bitwise complement of m
                sample_d = {1'b0, ~douta[9:0]};
            end else begin
                // Positive half: 1024 + m
                sample_d = {1'b1, douta[9:0]};
            end
        end
    end

    assign addra        = addra_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule
`default_nettype wire
